// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: state encoding, default sizing and small helpers shared by
// mem_arbiter and its round-robin picker.
package mem_arb_pkg;

  localparam int ARB_NREQ    = 4;
  localparam int ARB_WIDTH   = 8;
  localparam int ARB_DEPTH   = 16;
  localparam int ARB_TIMEOUT = 8;

  // IDLE: choose a requester; ISSUE: one-cycle memory request;
  // WAIT: await the memory acknowledge; DONE: one-cycle ready pulse.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  // Width of a requester index; a lone requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector. The search starts one past
// the previous winner and wraps, so the previous winner is examined last.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int NREQ = ARB_NREQ,
  parameter int IDXW = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] last,
  output logic [IDXW-1:0] grant,
  output logic            any
);

  // Walk the candidates in rotated order and keep the first active one.
  always_comb begin
    logic [IDXW-1:0] cand;
    grant = '0;
    any   = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IDXW'((int'(last) + i) % NREQ);
      if (!any && req[cand]) begin
        any   = 1'b1;
        grant = cand;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter that funnels NREQ requesters into one
// memory port, one transaction at a time (IDLE -> ISSUE -> WAIT -> DONE).
// Optional WAIT watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
//
// Handshake: a requester holds req_valid_i with a stable payload until it
// sees its one-cycle req_ready_o pulse; the payload is captured at grant, so
// later changes do not affect the transaction in flight. On the memory side
// mem_valid_o is a one-cycle request and mem_ready_i is the acknowledge that
// arrives on some later cycle (read data is valid alongside it).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ    = ARB_NREQ,
  parameter int WIDTH   = ARB_WIDTH,
  parameter int DEPTH   = ARB_DEPTH,
  parameter int ADDR    = $clog2(DEPTH),
  parameter int TIMEOUT = ARB_TIMEOUT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NREQ-1:0]       req_valid_i,
  input  logic [NREQ-1:0]       req_wr_rd_i,
  input  logic [NREQ*ADDR-1:0]  req_addr_i,
  input  logic [NREQ*WIDTH-1:0] req_wdata_i,
  output logic [NREQ-1:0]       req_ready_o,
  output logic [WIDTH-1:0]      req_rdata_o,
  output logic                  timeout_o,
  output logic                  mem_valid_o,
  output logic                  mem_wr_rd_o,
  output logic [ADDR-1:0]       mem_addr_o,
  output logic [WIDTH-1:0]      mem_wdata_o,
  input  logic [WIDTH-1:0]      mem_rdata_i,
  input  logic                  mem_ready_i
);

  localparam int IDXW = idx_width(NREQ);

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("mem_arbiter: TIMEOUT must be at least 1");
  end

  // Current FSM state, kept as a named enum for observation.
  arb_state_e       state;
  logic [IDXW-1:0]  last_grant;
  logic [IDXW-1:0]  grant;
  logic [IDXW-1:0]  pick;
  logic             any_req;
  logic [ADDR-1:0]  pick_addr;
  logic [WIDTH-1:0] pick_wdata;
  logic [NREQ-1:0]  grant_onehot;

  rr_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_rr_pick (
    .req   (req_valid_i),
    .last  (last_grant),
    .grant (pick),
    .any   (any_req)
  );

  assign pick_addr    = req_addr_i[int'(pick)*ADDR +: ADDR];
  assign pick_wdata   = req_wdata_i[int'(pick)*WIDTH +: WIDTH];
  assign grant_onehot = NREQ'(1) << grant;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;
`else
  assign timeout_o = 1'b0;
`endif

  // Transaction FSM with all outputs registered alongside the state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      last_grant  <= IDXW'(NREQ - 1);
      grant       <= '0;
      mem_valid_o <= 1'b0;
      mem_wr_rd_o <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      req_ready_o <= '0;
      req_rdata_o <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      timeout_o   <= 1'b0;
      wait_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state       <= ISSUE;
            grant       <= pick;
            last_grant  <= pick;
            mem_valid_o <= 1'b1;
            mem_wr_rd_o <= req_wr_rd_i[pick];
            mem_addr_o  <= pick_addr;
            mem_wdata_o <= pick_wdata;
          end
        end
        ISSUE: begin
          state       <= WAIT;
          mem_valid_o <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
          wait_cnt    <= '0;
`endif
        end
        WAIT: begin
          if (mem_ready_i) begin
            state       <= DONE;
            req_ready_o <= grant_onehot;
            // Writes leave the shared read-data register untouched.
            if (!mem_wr_rd_o) begin
              req_rdata_o <= mem_rdata_i;
            end
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            // Watchdog expiry completes the transaction without read data.
            state       <= DONE;
            req_ready_o <= grant_onehot;
            timeout_o   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          state       <= IDLE;
          req_ready_o <= '0;
          mem_wr_rd_o <= 1'b0;
          mem_addr_o  <= '0;
          mem_wdata_o <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
          timeout_o   <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- NREQ, 4, number of requesters.
- WIDTH, 8, data width.
- DEPTH, 16, memory depth.
- ADDR, $clog2(DEPTH), address width.
- TIMEOUT, 8, WAIT-cycle limit.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk_i, in, 1, the single clock.
- rst_i, in, 1, asynchronous active-high reset.
- req_valid_i, in, NREQ, per-requester request.
- req_wr_rd_i, in, NREQ, 1=write, 0=read.
- req_addr_i, in, NREQ*ADDR, packed addresses; requester k at [k*ADDR +: ADDR].
- req_wdata_i, in, NREQ*WIDTH, packed write data.
- req_ready_o, out, NREQ, one-cycle completion pulse to the granted requester.
- req_rdata_o, out, WIDTH, shared read-data return.
- timeout_o, out, 1, completion-by-timeout pulse.
- mem_valid_o, out, 1, memory request.
- mem_wr_rd_o, out, 1, memory direction.
- mem_addr_o, out, ADDR, memory address.
- mem_wdata_o, out, WIDTH, memory write data.
- mem_rdata_i, in, WIDTH, memory read data.
- mem_ready_i, in, 1, memory acknowledge (asserted the cycle after it samples valid).

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT, DONE.
REQ-004 IDLE SHALL transition as follows:
- If any req_valid_i bit is set, select the grant round-robin, latch its wr_rd/addr/wdata, and go to ISSUE.
- Otherwise stay in IDLE.
REQ-005 Round-robin SHALL search starting at (last_grant+1) mod NREQ, upward with wrap, and update last_grant on each grant.
REQ-006 ISSUE SHALL drive mem_valid_o=1 with the latched payload for exactly one cycle, then go to WAIT.
REQ-007 WAIT SHALL hold mem_valid_o=0 and go to DONE on the first cycle with mem_ready_i=1.
REQ-008 On the WAIT->DONE edge, a read SHALL register mem_rdata_i into req_rdata_o; a write SHALL leave req_rdata_o unchanged.
REQ-009 DONE SHALL assert req_ready_o[grant]=1 (all other bits 0) for exactly one cycle, then go to IDLE unconditionally.
REQ-010 Latency SHALL be four cycles per transaction:
- grant edge to ISSUE: 1 cycle;
- req_ready_o pulse: 3 cycles after the grant cycle;
- next grant possible 4 cycles after the previous grant.
REQ-011 The payload SHALL be latched at grant; later changes to payload or req_valid_i SHALL NOT affect the transaction in flight.
REQ-012 A requester SHALL deassert req_valid_i at the edge ending its ready pulse; a valid still held in IDLE SHALL be treated as a new request.
REQ-013 mem_addr_o/mem_wdata_o/mem_wr_rd_o SHALL hold the latched payload from ISSUE through DONE, and SHALL be 0 in IDLE.
REQ-014 A single requester SHALL NOT be granted twice while another requester's valid has been pending since before the earlier grant.

Reset
REQ-015 rst_i=1 SHALL asynchronously force the following:
- state IDLE;
- last_grant=NREQ-1, so requester 0 wins first;
- all outputs 0, including req_rdata_o;
- timeout counter 0.
REQ-016 Reset mid-transaction SHALL drop the transaction with no ready pulse; the requester reissues it.

Configuration
REQ-017 Macro MEM_ARB_TIMEOUT_EN defined SHALL enable the WAIT watchdog:
- a counter increments each WAIT cycle without mem_ready_i;
- on reaching TIMEOUT it goes to DONE, pulsing req_ready_o[grant] together with timeout_o=1;
- req_rdata_o is unchanged on a timeout.
REQ-018 With MEM_ARB_TIMEOUT_EN undefined, WAIT SHALL wait indefinitely, timeout_o SHALL be tied 0, and no counter SHALL be synthesized.

Structure
REQ-019 Package mem_arb_pkg SHALL hold the state typedef (IDLE/ISSUE/WAIT/DONE) and the default WIDTH/DEPTH/NREQ/TIMEOUT constants.
REQ-020 Grant selection SHALL be a combinational sub-module rr_pick (inputs req vector and last_grant; outputs grant index and any-valid).

Verification (NREQ=4, connected to the team's 16x8 memory)
REQ-021 Single write then read: req0 writes addr 3 = 0xA5, then reads addr 3 -> req_ready_o[0] pulses 3 cycles after each grant; read gives req_rdata_o=0xA5.
REQ-022 Contention: req0..req3 all valid in the same cycle, each writing addr k = 0x10+k -> grants in order 0,1,2,3, ready pulses 4 cycles apart; readback of addrs 0..3 gives 0x10..0x13.
REQ-023 Fairness: req1 held continuously with req2 pending -> grant sequence 1,2,1,2; neither is granted twice in a row.
REQ-024 Payload hold: req2 changes req_addr_i from 5 to 9 the cycle after grant -> memory sees addr 5 only.
REQ-025 Reset mid-WAIT: rst_i asserted during WAIT -> all outputs 0 immediately, no ready pulse; next request from req3 is granted to req3 (req0 has priority only if also valid).
REQ-026 Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT=8): mem_ready_i forced 0 -> timeout_o and req_ready_o[grant] pulse together with req_rdata_o unchanged; without the macro, the FSM stays in WAIT and timeout_o stays 0.
